// File: rtl/vga_draw_pkg.sv
// Shared screen geometry, VGA field types and sequencer state encoding
// for the VGA drawing path.
package vga_draw_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [7:0] vga_x_t;
  typedef logic [6:0] vga_y_t;
  typedef logic [2:0] vga_col_t;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FIN} seq_state_t;
endpackage

// File: rtl/reuleaux_frame_sequencer_if.sv
// User/reuleaux/VGA signal bundle around the frame sequencer.
// master = the sequencer itself, slave = its surroundings.
interface reuleaux_frame_sequencer_if;
  import vga_draw_pkg::*;

  logic     start;
  vga_col_t colour;
  vga_x_t   centre_x;
  vga_y_t   centre_y;
  logic [7:0] diameter;
  logic     done;

  logic     r_start;
  vga_col_t r_colour;
  vga_x_t   r_centre_x;
  vga_y_t   r_centre_y;
  logic [7:0] r_diameter;
  logic     r_done;
  vga_x_t   r_vga_x;
  vga_y_t   r_vga_y;
  vga_col_t r_vga_colour;
  logic     r_vga_plot;

  vga_x_t   vga_x;
  vga_y_t   vga_y;
  vga_col_t vga_colour;
  logic     vga_plot;

  modport master (
    input  start, colour, centre_x, centre_y, diameter,
    input  r_done, r_vga_x, r_vga_y, r_vga_colour, r_vga_plot,
    output done, r_start, r_colour, r_centre_x, r_centre_y, r_diameter,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output start, colour, centre_x, centre_y, diameter,
    output r_done, r_vga_x, r_vga_y, r_vga_colour, r_vga_plot,
    input  done, r_start, r_colour, r_centre_x, r_centre_y, r_diameter,
    input  vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/reuleaux_frame_sequencer_clear.sv
// Column-major screen sweep: y runs fastest, x steps when y wraps.
// last flags the bottom-right pixel; the whole counter wraps to (0,0) after it.
module screen_clear_counter
  import vga_draw_pkg::vga_x_t, vga_draw_pkg::vga_y_t;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output vga_x_t x,
  output vga_y_t y,
  output logic   last
);
  localparam vga_x_t X_LAST = vga_x_t'(SCREEN_W - 1);
  localparam vga_y_t Y_LAST = vga_y_t'(SCREEN_H - 1);

  vga_x_t x_q, x_d;
  vga_y_t y_q, y_d;
  logic   x_end, y_end;

  assign x_end = (x_q == X_LAST);
  assign y_end = (y_q == Y_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (y_end) begin
        y_d = '0;
        x_d = x_end ? '0 : x_q + 8'd1;
      end else begin
        y_d = y_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end && y_end;
endmodule

// File: rtl/reuleaux_frame_sequencer.sv
// Frame sequencer: latch shape args, clear the screen, then run one reuleaux
// draw while owning the VGA write port. Define REULEAUX_CLIP_EN to drop
// off-screen reuleaux plots.
module reuleaux_frame_sequencer
  import vga_draw_pkg::vga_x_t, vga_draw_pkg::vga_y_t, vga_draw_pkg::vga_col_t,
         vga_draw_pkg::seq_state_t, vga_draw_pkg::IDLE, vga_draw_pkg::CLEAR,
         vga_draw_pkg::DRAW, vga_draw_pkg::FIN;
#(
  parameter int       SCREEN_W  = 160,
  parameter int       SCREEN_H  = 120,
  parameter vga_col_t BG_COLOUR = 3'b000
) (
  input logic clk,
  input logic rst_n,
  reuleaux_frame_sequencer_if.master bus
);
  seq_state_t state_q;

  logic       done_q, r_start_q;
  vga_col_t   r_colour_q;
  vga_x_t     r_centre_x_q;
  vga_y_t     r_centre_y_q;
  logic [7:0] r_diameter_q;
  vga_x_t     vga_x_q;
  vga_y_t     vga_y_q;
  vga_col_t   vga_colour_q;
  logic       vga_plot_q;

  logic   clr_en, clr_last;
  vga_x_t clr_x;
  vga_y_t clr_y;

  assign clr_en = (state_q == CLEAR);

  screen_clear_counter #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clr_en),
    .x     (clr_x),
    .y     (clr_y),
    .last  (clr_last)
  );

  logic pass_plot;
`ifdef REULEAUX_CLIP_EN
  localparam vga_x_t X_LAST = vga_x_t'(SCREEN_W - 1);
  localparam vga_y_t Y_LAST = vga_y_t'(SCREEN_H - 1);
  assign pass_plot = bus.r_vga_plot && (bus.r_vga_x <= X_LAST) && (bus.r_vga_y <= Y_LAST);
`else
  assign pass_plot = bus.r_vga_plot;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      r_start_q    <= 1'b0;
      r_colour_q   <= '0;
      r_centre_x_q <= '0;
      r_centre_y_q <= '0;
      r_diameter_q <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vga_plot_q <= 1'b0;
          done_q     <= 1'b0;
          if (bus.start) begin
            r_colour_q   <= bus.colour;
            r_centre_x_q <= bus.centre_x;
            r_centre_y_q <= bus.centre_y;
            r_diameter_q <= bus.diameter;
            state_q      <= CLEAR;
          end
        end
        CLEAR: begin
          vga_x_q      <= clr_x;
          vga_y_q      <= clr_y;
          vga_colour_q <= BG_COLOUR;
          vga_plot_q   <= 1'b1;
          if (clr_last) begin
            r_start_q <= 1'b1;
            state_q   <= DRAW;
          end
        end
        DRAW: begin
          // Plot issued alongside r_done is still forwarded.
          vga_x_q      <= bus.r_vga_x;
          vga_y_q      <= bus.r_vga_y;
          vga_colour_q <= bus.r_vga_colour;
          vga_plot_q   <= pass_plot;
          if (bus.r_done) begin
            r_start_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end
        end
        FIN: begin
          vga_plot_q <= 1'b0;
          if (!bus.start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.r_start    = r_start_q;
  assign bus.r_colour   = r_colour_q;
  assign bus.r_centre_x = r_centre_x_q;
  assign bus.r_centre_y = r_centre_y_q;
  assign bus.r_diameter = r_diameter_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_reuleaux_frame_sequencer.sv
// Directed bench for reuleaux_frame_sequencer with a behavioural reuleaux stub
// driven straight from the stimulus sequence.
module tb_reuleaux_frame_sequencer;
  import vga_draw_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reuleaux_frame_sequencer_if bus();

  reuleaux_frame_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stub(input vga_x_t x, input vga_y_t y, input vga_col_t c,
                      input logic p, input logic d);
    bus.r_vga_x      = x;
    bus.r_vga_y      = y;
    bus.r_vga_colour = c;
    bus.r_vga_plot   = p;
    bus.r_done       = d;
  endtask

  task automatic wait_rstart(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      tick();
      if (bus.r_start) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  logic exp_clip_plot;

  initial begin
    int   n, bad, ex, ey, lx, ly, first_i;
    logic got;

`ifdef REULEAUX_CLIP_EN
    exp_clip_plot = 1'b0;
`else
    exp_clip_plot = 1'b1;
`endif
    bus.start = 1'b0; bus.colour = '0; bus.centre_x = '0;
    bus.centre_y = '0; bus.diameter = '0;
    stub(0, 0, 0, 0, 0);

    // Reset state
    tick(); tick();
    chk("rst_plot",   32'(bus.vga_plot), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_rstart", 32'(bus.r_start), 32'd0);
    chk("rst_vga_x",  32'(bus.vga_x), 32'd0);
    chk("rst_rcx",    32'(bus.r_centre_x), 32'd0);
    chk("rst_state",  32'(dut.state_q), 32'(IDLE));

    // Reset at cycle 500 of a clear
    rst_n = 1'b1;
    bus.colour = 3'd5; bus.centre_x = 8'd80; bus.centre_y = 7'd60; bus.diameter = 8'd80;
    bus.start = 1'b1;
    repeat (500) tick();
    chk("midclr_plot", 32'(bus.vga_plot), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_plot",  32'(bus.vga_plot), 32'd0);
    chk("midrst_done",  32'(bus.done), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;

    // Full clear sweep from (0,0), centre_x changed mid-clear
    n = 0; bad = 0; ex = 0; ey = 0; lx = -1; ly = -1; first_i = -1; got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      tick();
      if (i == 100) bus.centre_x = 8'd20;
      if (bus.vga_plot) begin
        if (n == 0) begin
          first_i = i;
          chk("first_x", 32'(bus.vga_x), 32'd0);
          chk("first_y", 32'(bus.vga_y), 32'd0);
        end
        if (int'(bus.vga_x) != ex || int'(bus.vga_y) != ey || bus.vga_colour != 3'd0) bad++;
        n++;
        lx = int'(bus.vga_x); ly = int'(bus.vga_y);
        if (ey == 119) begin ey = 0; ex++; end else ey++;
      end
      if (bus.r_start) got = 1'b1;
    end
    chk("clr_reach_draw", 32'(got), 32'd1);
    chk("clr_first_lat",  32'(first_i), 32'd1);
    chk("clr_count",      32'(n), 32'd19200);
    chk("clr_order_bad",  32'(bad), 32'd0);
    chk("clr_last_x",     32'(lx), 32'd159);
    chk("clr_last_y",     32'(ly), 32'd119);
    chk("r_colour",       32'(bus.r_colour), 32'd5);
    chk("r_centre_x",     32'(bus.r_centre_x), 32'd80);
    chk("r_centre_y",     32'(bus.r_centre_y), 32'd60);
    chk("r_diameter",     32'(bus.r_diameter), 32'd80);
    tick(); tick();
    chk("draw_rstart_hold", 32'(bus.r_start), 32'd1);
    chk("draw_idle_plot",   32'(bus.vga_plot), 32'd0);
    chk("draw_done",        32'(bus.done), 32'd0);

    // Stub plots three pixels, the last with r_done
    stub(10, 20, 1, 1, 0); tick();
    chk("p1_x", 32'(bus.vga_x), 32'd10);
    chk("p1_y", 32'(bus.vga_y), 32'd20);
    chk("p1_c", 32'(bus.vga_colour), 32'd1);
    chk("p1_plot", 32'(bus.vga_plot), 32'd1);
    stub(11, 21, 2, 1, 0); tick();
    chk("p2_x", 32'(bus.vga_x), 32'd11);
    chk("p2_y", 32'(bus.vga_y), 32'd21);
    chk("p2_c", 32'(bus.vga_colour), 32'd2);
    chk("p2_rcx", 32'(bus.r_centre_x), 32'd80);
    stub(12, 22, 3, 1, 1); tick();
    chk("p3_x", 32'(bus.vga_x), 32'd12);
    chk("p3_plot", 32'(bus.vga_plot), 32'd1);
    chk("p3_rstart", 32'(bus.r_start), 32'd0);
    chk("p3_done", 32'(bus.done), 32'd1);
    stub(0, 0, 0, 0, 0); tick();
    chk("fin_plot", 32'(bus.vga_plot), 32'd0);

    // FIN holds while start stays high
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("fin_hold_done", 32'(bus.done), 32'd1);
    end
    bus.start = 1'b0;
    tick();
    chk("fin_exit_done",  32'(bus.done), 32'd0);
    chk("fin_exit_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);

    // Second frame: off-screen plot then in-range plot
    bus.start = 1'b1;
    wait_rstart("f2_reach_draw");
    chk("f2_rcx", 32'(bus.r_centre_x), 32'd20);
    stub(170, 60, 4, 1, 0); tick();
    chk("clip_x", 32'(bus.vga_x), 32'd170);
    chk("clip_plot", 32'(bus.vga_plot), 32'(exp_clip_plot));
    stub(159, 119, 4, 1, 1); tick();
    chk("edge_plot", 32'(bus.vga_plot), 32'd1);
    chk("edge_x", 32'(bus.vga_x), 32'd159);
    chk("edge_y", 32'(bus.vga_y), 32'd119);
    chk("f2_done", 32'(bus.done), 32'd1);
    stub(0, 0, 0, 0, 0);
    bus.start = 1'b0;
    tick(); tick();
    chk("f2_idle_done", 32'(bus.done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
